// File: rtl/arith_pkg.sv
// Shared definitions for the serial adder: FSM state encodings, default
// operand/chunk widths and a helper that sizes the chunk counter.
package arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CHUNK = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Smallest counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder.
// Ports:
//   x, y      : CHUNK-bit addends
//   cin       : carry in to bit 0
//   s         : CHUNK-bit sum
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (for signed overflow detection)
module chunk_adder #(
  parameter int unsigned CHUNK = 1
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  // Carry chain: w_c[i] is the carry into bit i.
  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]     = x[i] ^ y[i] ^ w_c[i];
      w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout     = w_c[CHUNK];
  assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor processing CHUNK bits per clock.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a new operation (accepted only when idle)
//   sub        : 0 = a + b, 1 = a - b (sampled with start)
//   a, b       : WIDTH-bit operands (sampled with start)
//   busy       : operation in progress (RUN or DONE)
//   done       : one-cycle pulse, result valid
//   sum        : WIDTH-bit result, modulo 2^WIDTH
//   carry_out  : carry out of the MSB (1 = no borrow when subtracting)
//   overflow   : two's-complement signed overflow
module serial_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = cnt_width(N);

  state_e             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_cnt;

  logic [CHUNK-1:0]   w_s;
  logic               w_cout;
  logic               w_c_msb_in;
  logic               w_last;
  logic [WIDTH-1:0]   w_sum_next;

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .x        (r_a[CHUNK-1:0]),
    .y        (r_b[CHUNK-1:0]),
    .cin      (r_carry),
    .s        (w_s),
    .cout     (w_cout),
    .c_msb_in (w_c_msb_in)
  );

  // New chunk enters at the MSB side; works unchanged when CHUNK == WIDTH.
  assign w_sum_next = WIDTH'({w_s, r_sum} >> CHUNK);
  assign w_last     = (r_cnt == CNT_W'(N - 1));

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 rides in on the carry.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_sum   <= w_sum_next;
          r_carry <= w_cout;
          if (w_last) begin
            r_ovf   <= w_c_msb_in ^ w_cout;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_carry;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (CHUNK = 1, 4, 8, all
// WIDTH = 8) share operand inputs and have individual start lines.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_v [3];
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [7:0] sum_v   [3];
  logic       co_v    [3];
  logic       ov_v    [3];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .a(a), .b(b),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]),
    .carry_out(co_v[0]), .overflow(ov_v[0])
  );

  serial_adder #(.WIDTH(8), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .a(a), .b(b),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
    .carry_out(co_v[1]), .overflow(ov_v[1])
  );

  serial_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .a(a), .b(b),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]),
    .carry_out(co_v[2]), .overflow(ov_v[2])
  );

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
    int         start_edge;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int sel, input exp_t e);
    case (sel)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Monitor side: pop one expectation per observed done pulse.
  task automatic pop_check(input int sel);
    exp_t e;
    if (qsize(sel) == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL c%0d_unexpected_done: got done=1 sum=%0h expected no pending op",
               sel, sum_v[sel]);
      return;
    end
    case (sel)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    cmp($sformatf("c%0d_sum", sel),      32'(sum_v[sel]), 32'(e.s));
    cmp($sformatf("c%0d_carry", sel),    32'(co_v[sel]),  32'(e.co));
    cmp($sformatf("c%0d_overflow", sel), 32'(ov_v[sel]),  32'(e.ov));
    cmp($sformatf("c%0d_latency", sel),  32'(cyc - e.start_edge), 32'(e.lat));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) pop_check(i);
      end
    end
  end

  // Drive one request; optionally record its expected result.
  task automatic issue(input int sel, input logic s, input logic [7:0] aa,
                       input logic [7:0] bb, input logic [7:0] es,
                       input logic eco, input logic eov, input int lat,
                       input bit track);
    exp_t e;
    @(negedge clk);
    a = aa;
    b = bb;
    sub = s;
    start_v[sel] = 1'b1;
    if (track) begin
      e.s = es; e.co = eco; e.ov = eov; e.start_edge = cyc + 1; e.lat = lat;
      push(sel, e);
    end
    @(negedge clk);
    start_v[sel] = 1'b0;
    // Scramble inputs: captured operands must not depend on them any more.
    a   = 8'($urandom);
    b   = 8'($urandom);
    sub = 1'($urandom);
    cmp($sformatf("c%0d_busy_after_start", sel), 32'(busy_v[sel]), 32'd1);
  endtask

  // Bounded wait for the instance to go idle, then check result holds.
  task automatic wait_idle(input int sel, input logic [7:0] es,
                           input logic eco, input logic eov);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy_v[sel]) break;
    end
    cmp($sformatf("c%0d_idle_reached", sel), 32'(busy_v[sel]), 32'd0);
    repeat (2) @(negedge clk);
    cmp($sformatf("c%0d_sum_hold", sel),   32'(sum_v[sel]), 32'(es));
    cmp($sformatf("c%0d_carry_hold", sel), 32'(co_v[sel]),  32'(eco));
    cmp($sformatf("c%0d_ovf_hold", sel),   32'(ov_v[sel]),  32'(eov));
    cmp($sformatf("c%0d_queue_drained", sel), 32'(qsize(sel)), 32'd0);
  endtask

  task automatic op(input int sel, input logic s, input logic [7:0] aa,
                    input logic [7:0] bb, input logic [7:0] es,
                    input logic eco, input logic eov, input int lat);
    issue(sel, s, aa, bb, es, eco, eov, lat, 1'b1);
    wait_idle(sel, es, eco, eov);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    sub = 1'b0;
    a   = 8'h00;
    b   = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("c%0d_rst_busy", i), 32'(busy_v[i]), 32'd0);
      cmp($sformatf("c%0d_rst_done", i), 32'(done_v[i]), 32'd0);
      cmp($sformatf("c%0d_rst_sum", i),  32'(sum_v[i]),  32'd0);
    end
    rst_n = 1'b1;

    // CHUNK = 1
    op(0, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 8);
    op(0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 8);
    op(0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 8);
    op(0, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 8);
    op(0, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 8);
    op(0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 8);
    op(0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8);
    op(0, 1'b0, 8'hC3, 8'h5A, 8'h1D, 1'b1, 1'b0, 8);

    // CHUNK = 4
    op(1, 1'b0, 8'hA5, 8'h3C, 8'hE1, 1'b0, 1'b0, 2);
    op(1, 1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1, 2);
    op(1, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 2);

    // CHUNK = WIDTH: single RUN cycle
    op(2, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1);
    op(2, 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1);

    // Second start while busy must be ignored.
    issue(0, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 8, 1'b1);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; sub = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle(0, 8'h02, 1'b0, 1'b0);

    // Reset in the 4th RUN cycle aborts the operation.
    issue(0, 1'b0, 8'h33, 8'h44, 8'h00, 1'b0, 1'b0, 8, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmp("abort_busy",  32'(busy_v[0]), 32'd0);
    cmp("abort_done",  32'(done_v[0]), 32'd0);
    cmp("abort_sum",   32'(sum_v[0]),  32'd0);
    cmp("abort_carry", 32'(co_v[0]),   32'd0);
    cmp("abort_ovf",   32'(ov_v[0]),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    cmp("abort_still_idle", 32'(busy_v[0]), 32'd0);
    op(0, 1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 8);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("c%0d_final_drain", i), 32'(qsize(i)), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
